// File: rtl/load_unit_if.sv
// Load unit bus bundle: execute-stage request, data-memory read port and
// result channel.
//   master : the environment side (execute stage, memory, result consumer)
//   slave  : the load unit itself
// Request channel : req_valid/req_ready, req_funct3, req_addr, req_tag
// Memory channel  : mem_req_valid/mem_req_ready, mem_addr, mem_rvalid,
//                   mem_rdata, mem_err
// Result channel  : rsp_valid/rsp_ready, rsp_data, rsp_tag, rsp_fault
interface load_unit_if #(
  parameter int N      = 32,
  parameter int F3_LEN = 3,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [F3_LEN-1:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [N-1:0]      mem_rdata;
  logic              mem_err;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [1:0]        rsp_fault;

  modport master (
    output req_valid, req_funct3, req_addr, req_tag,
    input  req_ready,
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_rvalid, mem_rdata, mem_err,
    input  rsp_valid, rsp_data, rsp_tag, rsp_fault,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_tag,
    output req_ready,
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_rvalid, mem_rdata, mem_err,
    output rsp_valid, rsp_data, rsp_tag, rsp_fault,
    input  rsp_ready
  );
endinterface

// File: rtl/load_unit.sv
// Sequential RISC-V load unit between execute and the data-memory bus.
// Accepts one load per request handshake, issues naturally aligned N-bit
// reads (two beats for a misaligned access when SPLIT_EN=1), merges and
// sign/zero-extends the addressed data, and returns it with its tag and a
// fault code (00 ok, 01 misaligned, 10 bus error, 11 illegal funct3).
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : load_unit_if.slave (request, memory and result channels)
//
// state | meaning
// IDLE  | ready for a new request
// REQ0  | presenting the read of the first (or only) beat
// WAIT0 | waiting for beat-0 read data
// REQ1  | presenting the read of the following beat
// WAIT1 | waiting for beat-1 read data
// DONE  | result valid, held until rsp_ready
module load_unit #(
  parameter int N        = 32,
  parameter int F3_LEN   = 3,
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 5,
  parameter int SPLIT_EN = 1
) (
  input logic       clk,
  input logic       rst_n,
  load_unit_if.slave bus
);
  localparam int NB    = N / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t            state_q, state_n;
  logic [F3_LEN-1:0] f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [N-1:0]      beat0_q;
  logic [N-1:0]      data_q;
  logic [1:0]        fault_q;

  // Access size in bytes; 0 marks an illegal funct3 for this XLEN.
  function automatic logic [3:0] size_of(input logic [F3_LEN-1:0] f3);
    logic [3:0] s;
    s = 4'd0;
    case (f3)
      F3_LEN'(3'b000), F3_LEN'(3'b100): s = 4'd1;
      F3_LEN'(3'b001), F3_LEN'(3'b101): s = 4'd2;
      F3_LEN'(3'b010):                  s = 4'd4;
      F3_LEN'(3'b011):                  s = (N == 64) ? 4'd8 : 4'd0;
      F3_LEN'(3'b110):                  s = (N == 64) ? 4'd4 : 4'd0;
      default:                          s = 4'd0;
    endcase
    return s;
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [3:0] sz);
    return (int'(off) + int'(sz)) > NB;
  endfunction

  logic [3:0]       acc_sz, sz_q;
  logic             acc_cross, cross_q;
  logic [OFF_W-1:0] off_q;
  logic [ADDR_W-1:0] base_addr;

  assign acc_sz    = size_of(bus.req_funct3);
  assign acc_cross = crosses(bus.req_addr[OFF_W-1:0], acc_sz);
  assign sz_q      = size_of(f3_q);
  assign off_q     = addr_q[OFF_W-1:0];
  assign cross_q   = crosses(off_q, sz_q);
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Merge/extract: shift the (possibly two-beat) window down by the byte
  // offset, keep sz bytes, then fill the upper bits with sign or zeros.
  logic [2*N-1:0] raw, shifted;
  logic [N-1:0]   slice, mask, ext;
  logic           sbit;

  always_comb begin
    raw     = (state_q == WAIT1) ? {bus.mem_rdata, beat0_q} : {{N{1'b0}}, bus.mem_rdata};
    shifted = raw >> {off_q, 3'b000};
    slice   = shifted[N-1:0];
    mask    = '0;
    sbit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i < 8 * int'(sz_q)) mask[i] = 1'b1;
      if (i == 8 * int'(sz_q) - 1) sbit = slice[i];
    end
    ext = (slice & mask) | ((!f3_q[2] && sbit) ? ~mask : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (acc_sz == 4'd0)                    state_n = DONE;
          else if (acc_cross && (SPLIT_EN == 0)) state_n = DONE;
          else                                   state_n = REQ0;
        end
      end
      REQ0:  if (bus.mem_req_ready) state_n = WAIT0;
      WAIT0: begin
        if (bus.mem_rvalid) begin
          if (bus.mem_err)  state_n = DONE;
          else if (cross_q) state_n = REQ1;
          else              state_n = DONE;
        end
      end
      REQ1:  if (bus.mem_req_ready) state_n = WAIT1;
      WAIT1: if (bus.mem_rvalid) state_n = DONE;
      DONE:  if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q    <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      beat0_q <= '0;
      data_q  <= '0;
      fault_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            f3_q   <= bus.req_funct3;
            addr_q <= bus.req_addr;
            tag_q  <= bus.req_tag;
            data_q <= '0;
            if (acc_sz == 4'd0)                    fault_q <= 2'b11;
            else if (acc_cross && (SPLIT_EN == 0)) fault_q <= 2'b01;
            else                                   fault_q <= 2'b00;
          end
        end
        WAIT0: begin
          if (bus.mem_rvalid) begin
            beat0_q <= bus.mem_rdata;
            if (bus.mem_err) begin
              fault_q <= 2'b10;
              data_q  <= '0;
            end else if (!cross_q) begin
              data_q <= ext;
            end
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid) begin
            if (bus.mem_err) begin
              fault_q <= 2'b10;
              data_q  <= '0;
            end else begin
              data_q <= ext;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready     = (state_q == IDLE);
    bus.mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
    bus.mem_addr      = '0;
    if (state_q == REQ0)      bus.mem_addr = base_addr;
    else if (state_q == REQ1) bus.mem_addr = base_addr + ADDR_W'(NB);
    bus.rsp_valid = (state_q == DONE);
    bus.rsp_data  = data_q;
    bus.rsp_tag   = tag_q;
    bus.rsp_fault = fault_q;
  end
endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_unit_if #(.N(32), .F3_LEN(3), .ADDR_W(32), .TAG_W(5)) ifa ();
  load_unit_if #(.N(32), .F3_LEN(3), .ADDR_W(32), .TAG_W(5)) ifb ();

  load_unit #(.N(32), .F3_LEN(3), .ADDR_W(32), .TAG_W(5), .SPLIT_EN(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  load_unit #(.N(32), .F3_LEN(3), .ADDR_W(32), .TAG_W(5), .SPLIT_EN(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  // memory model for dut_a
  logic        gnt = 1'b1;
  int          extra = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        pend = 1'b0;
  int          dly = 0;
  logic [31:0] pend_addr = '0;
  int          rd_total = 0;
  logic [31:0] rd_log [256];
  int          ns_reqs = 0;

  assign ifa.mem_req_ready = gnt;
  assign ifb.mem_req_ready = 1'b1;
  assign ifb.mem_rvalid    = 1'b0;
  assign ifb.mem_rdata     = '0;
  assign ifb.mem_err       = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return 32'h8899AABB;
      32'h104: return 32'h11223344;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    ifa.mem_rvalid = 1'b0;
    ifa.mem_err    = 1'b0;
    ifa.mem_rdata  = '0;
    if (pend) begin
      if (dly == 0) begin
        ifa.mem_rvalid = 1'b1;
        ifa.mem_rdata  = mem_rd(pend_addr);
        ifa.mem_err    = (pend_addr == err_addr);
        pend = 1'b0;
      end else dly--;
    end
    if (ifa.mem_req_valid && ifa.mem_req_ready) begin
      pend = 1'b1;
      dly = extra;
      pend_addr = ifa.mem_addr;
      rd_log[rd_total[7:0]] = ifa.mem_addr;
      rd_total++;
    end
    if (ifb.mem_req_valid) ns_reqs++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] tg,
                         output logic [31:0] d, output logic [1:0] f, output logic [4:0] t,
                         output int lat);
    int w;
    w = 0;
    while (!ifa.req_ready && w < 20) begin step(); w++; end
    ifa.req_valid = 1'b1; ifa.req_funct3 = f3; ifa.req_addr = a; ifa.req_tag = tg;
    step();
    ifa.req_valid = 1'b0;
    lat = 1;
    while (!ifa.rsp_valid && lat < 20) begin step(); lat++; end
    d = ifa.rsp_data; f = ifa.rsp_fault; t = ifa.rsp_tag;
    ifa.rsp_ready = 1'b1;
    step();
    ifa.rsp_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  f;
  logic [4:0]  t;
  int          lat, r0;

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_tests++; if (ifa.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b exp 1", ifa.req_ready); end
    n_tests++; if (ifa.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %0b exp 0", ifa.mem_req_valid); end
    n_tests++; if (ifa.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", ifa.mem_addr); end
    n_tests++; if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_tag, ifa.rsp_fault} !== '0) begin n_fail++; $display("FAIL reset_rsp got v=%0b d=%h t=%0d f=%0d exp all 0", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_tag, ifa.rsp_fault); end
  endtask

  task automatic test_byte();
    r0 = rd_total;
    do_load(3'b000, 32'h103, 5'd5, d, f, t, lat);
    n_tests++; if (d !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_data got %h exp ffffff88", d); end
    n_tests++; if (f !== 2'b00) begin n_fail++; $display("FAIL lb_fault got %0d exp 0", f); end
    n_tests++; if (t !== 5'd5) begin n_fail++; $display("FAIL lb_tag got %0d exp 5", t); end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lb_latency got %0d exp 3", lat); end
    n_tests++; if (rd_total - r0 !== 1) begin n_fail++; $display("FAIL lb_reads got %0d exp 1", rd_total - r0); end
    n_tests++; if (rd_log[r0[7:0]] !== 32'h100) begin n_fail++; $display("FAIL lb_addr got %h exp 100", rd_log[r0[7:0]]); end
  endtask

  task automatic test_half();
    do_load(3'b101, 32'h102, 5'd6, d, f, t, lat);
    n_tests++; if (d !== 32'h00008899) begin n_fail++; $display("FAIL lhu_data got %h exp 00008899", d); end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lhu_latency got %0d exp 3", lat); end
    r0 = rd_total;
    do_load(3'b001, 32'h103, 5'd7, d, f, t, lat);
    n_tests++; if (d !== 32'h00004488) begin n_fail++; $display("FAIL lh_split_data got %h exp 00004488", d); end
    n_tests++; if (f !== 2'b00) begin n_fail++; $display("FAIL lh_split_fault got %0d exp 0", f); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL lh_split_latency got %0d exp 5", lat); end
    n_tests++; if (rd_total - r0 !== 2) begin n_fail++; $display("FAIL lh_split_reads got %0d exp 2", rd_total - r0); end
    n_tests++; if (rd_log[r0[7:0]] !== 32'h100 || rd_log[8'(r0 + 1)] !== 32'h104) begin n_fail++; $display("FAIL lh_split_addrs got %h %h exp 100 104", rd_log[r0[7:0]], rd_log[8'(r0 + 1)]); end
  endtask

  task automatic test_split_word();
    do_load(3'b010, 32'h101, 5'd8, d, f, t, lat);
    n_tests++; if (d !== 32'h448899AA) begin n_fail++; $display("FAIL lw_split_data got %h exp 448899aa", d); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL lw_split_latency got %0d exp 5", lat); end
    do_load(3'b010, 32'h103, 5'd9, d, f, t, lat);
    n_tests++; if (d !== 32'h22334488) begin n_fail++; $display("FAIL lw_split103_data got %h exp 22334488", d); end
    ifb.req_valid = 1'b1; ifb.req_funct3 = 3'b010; ifb.req_addr = 32'h101; ifb.req_tag = 5'd7;
    step();
    ifb.req_valid = 1'b0;
    n_tests++; if (ifb.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL nosplit_rsp_valid got %0b exp 1", ifb.rsp_valid); end
    n_tests++; if (ifb.rsp_fault !== 2'b01) begin n_fail++; $display("FAIL nosplit_fault got %0d exp 1", ifb.rsp_fault); end
    n_tests++; if (ifb.rsp_data !== 32'h0 || ifb.rsp_tag !== 5'd7) begin n_fail++; $display("FAIL nosplit_data_tag got %h/%0d exp 0/7", ifb.rsp_data, ifb.rsp_tag); end
    ifb.rsp_ready = 1'b1;
    step();
    ifb.rsp_ready = 1'b0;
    n_tests++; if (ifb.req_ready !== 1'b1) begin n_fail++; $display("FAIL nosplit_req_ready got %0b exp 1", ifb.req_ready); end
    n_tests++; if (ns_reqs !== 0) begin n_fail++; $display("FAIL nosplit_bus_reqs got %0d exp 0", ns_reqs); end
  endtask

  task automatic test_illegal();
    r0 = rd_total;
    do_load(3'b011, 32'h100, 5'd2, d, f, t, lat);
    n_tests++; if (f !== 2'b11) begin n_fail++; $display("FAIL ld_rv32_fault got %0d exp 3", f); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL ld_rv32_latency got %0d exp 1", lat); end
    n_tests++; if (d !== 32'h0 || t !== 5'd2) begin n_fail++; $display("FAIL ld_rv32_data_tag got %h/%0d exp 0/2", d, t); end
    do_load(3'b110, 32'h100, 5'd3, d, f, t, lat);
    n_tests++; if (f !== 2'b11) begin n_fail++; $display("FAIL lwu_rv32_fault got %0d exp 3", f); end
    n_tests++; if (rd_total - r0 !== 0) begin n_fail++; $display("FAIL illegal_reads got %0d exp 0", rd_total - r0); end
  endtask

  task automatic test_bus_err();
    err_addr = 32'h104;
    r0 = rd_total;
    do_load(3'b010, 32'h102, 5'd4, d, f, t, lat);
    n_tests++; if (f !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL err_beat1 got f=%0d d=%h exp f=2 d=0", f, d); end
    n_tests++; if (lat !== 5 || rd_total - r0 !== 2) begin n_fail++; $display("FAIL err_beat1_timing got lat=%0d reads=%0d exp 5/2", lat, rd_total - r0); end
    err_addr = 32'h100;
    r0 = rd_total;
    do_load(3'b010, 32'h102, 5'd4, d, f, t, lat);
    n_tests++; if (f !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL err_beat0 got f=%0d d=%h exp f=2 d=0", f, d); end
    n_tests++; if (lat !== 3 || rd_total - r0 !== 1) begin n_fail++; $display("FAIL err_beat0_skip got lat=%0d reads=%0d exp 3/1", lat, rd_total - r0); end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_stall();
    int w;
    gnt = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_funct3 = 3'b010; ifa.req_addr = 32'h100; ifa.req_tag = 5'd3;
    step();
    ifa.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ifa.mem_req_valid !== 1'b1 || ifa.mem_addr !== 32'h100) begin n_fail++; $display("FAIL stall_mem_addr cyc %0d got v=%0b a=%h exp 1/100", i, ifa.mem_req_valid, ifa.mem_addr); end
      if (i < 3) step();
    end
    gnt = 1'b1;
    w = 0;
    while (!ifa.rsp_valid && w < 20) begin step(); w++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_data !== 32'h8899AABB || ifa.rsp_tag !== 5'd3 || ifa.req_ready !== 1'b0) begin n_fail++; $display("FAIL rsp_hold cyc %0d got v=%0b d=%h t=%0d rr=%0b exp 1/8899aabb/3/0", i, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_tag, ifa.req_ready); end
      step();
    end
    ifa.rsp_ready = 1'b1;
    step();
    ifa.rsp_ready = 1'b0;
    n_tests++; if (ifa.req_ready !== 1'b1 || ifa.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL after_rsp got rr=%0b v=%0b exp 1/0", ifa.req_ready, ifa.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    do_load(3'b100, 32'h105, 5'd10, d, f, t, lat);
    n_tests++; if (d !== 32'h00000033) begin n_fail++; $display("FAIL b2b_lbu got %h exp 00000033", d); end
    do_load(3'b001, 32'h106, 5'd11, d, f, t, lat);
    n_tests++; if (d !== 32'h00001122 || t !== 5'd11) begin n_fail++; $display("FAIL b2b_lh got %h/%0d exp 00001122/11", d, t); end
    do_load(3'b000, 32'h104, 5'd12, d, f, t, lat);
    n_tests++; if (d !== 32'h00000044) begin n_fail++; $display("FAIL b2b_lb got %h exp 00000044", d); end
  endtask

  task automatic test_reset_mid();
    extra = 3;
    ifa.req_valid = 1'b1; ifa.req_funct3 = 3'b010; ifa.req_addr = 32'h100; ifa.req_tag = 5'd9;
    step();
    ifa.req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++; if (ifa.req_ready !== 1'b1 || ifa.mem_req_valid !== 1'b0 || ifa.mem_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_req got rr=%0b mv=%0b ma=%h exp 1/0/0", ifa.req_ready, ifa.mem_req_valid, ifa.mem_addr); end
    n_tests++; if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_tag, ifa.rsp_fault} !== '0) begin n_fail++; $display("FAIL midreset_rsp got v=%0b d=%h t=%0d f=%0d exp all 0", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_tag, ifa.rsp_fault); end
    step(); step(); step();
    n_tests++; if (ifa.rsp_valid !== 1'b0 || ifa.req_ready !== 1'b1) begin n_fail++; $display("FAIL late_rvalid got v=%0b rr=%0b exp 0/1", ifa.rsp_valid, ifa.req_ready); end
    extra = 0;
    do_load(3'b100, 32'h100, 5'd1, d, f, t, lat);
    n_tests++; if (d !== 32'h000000BB || f !== 2'b00 || lat !== 3) begin n_fail++; $display("FAIL post_reset_lbu got d=%h f=%0d lat=%0d exp 000000bb/0/3", d, f, lat); end
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_funct3 = '0; ifa.req_addr = '0; ifa.req_tag = '0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_funct3 = '0; ifb.req_addr = '0; ifb.req_tag = '0; ifb.rsp_ready = 1'b0;
    test_reset();
    test_byte();
    test_half();
    test_split_word();
    test_illegal();
    test_bus_err();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
